// File: rtl/vmult_pkg.sv
// vmult_pkg: fp16 constants, operand class type and classifier shared by the vmult_p multiplier
package vmult_pkg;
  localparam int FP16_BIAS = 15;
  localparam int FP16_EXP_MAX = 31;
  localparam logic [15:0] FP16_INF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp16_class_t;
  // exp==0 (including subnormals) counts as zero
  function automatic fp16_class_t fp16_class(input logic [15:0] x);
    return x[14:10] == 5'd0 ? ZERO : x[14:10] != 5'd31 ? NORM : x[9:0] != 10'd0 ? NAN : INF;
  endfunction
endpackage

// File: rtl/vmult_p_core.sv
// vmult_p_core: combinational fp16 unpack/multiply/normalize/round
// Ports: i_a, i_b fp16 operands; o_product fp16 result; o_overflow finite*finite overflow.
// Build option: VMULT_RNE_EN selects round-to-nearest-even, otherwise truncate.
module vmult_p_core (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_product,
  output logic        o_overflow
);
  import vmult_pkg::*;
  fp16_class_t w_ca, w_cb;
  logic w_sign, w_hi;
  logic [21:0] w_mant;
  logic [9:0] w_frac, w_frac_r;
  logic signed [7:0] w_exp, w_exp_r;
  assign w_ca = fp16_class(i_a);
  assign w_cb = fp16_class(i_b);
  assign w_sign = i_a[15] ^ i_b[15];
  assign w_mant = {11'd0, 1'b1, i_a[9:0]} * {11'd0, 1'b1, i_b[9:0]};
  assign w_hi = w_mant[21];
  assign w_frac = w_hi ? w_mant[20:11] : w_mant[19:10];
  assign w_exp = 8'(i_a[14:10]) + 8'(i_b[14:10]) + 8'(w_hi) - 8'(FP16_BIAS);
`ifdef VMULT_RNE_EN
  logic w_guard, w_sticky, w_up;
  logic [10:0] w_sum;
  assign w_guard = w_hi ? w_mant[10] : w_mant[9];
  assign w_sticky = w_hi ? |w_mant[9:0] : |w_mant[8:0];
  assign w_up = w_guard & (w_sticky | w_frac[0]);
  // a carry out leaves the fraction at zero, so only the exponent needs bumping
  assign w_sum = {1'b0, w_frac} + 11'(w_up);
  assign w_frac_r = w_sum[9:0];
  assign w_exp_r = w_exp + 8'(w_sum[10]);
`else
  logic w_unused;
  assign w_unused = ^w_mant[9:0];
  assign w_frac_r = w_frac;
  assign w_exp_r = w_exp;
`endif
  always_comb begin
    o_overflow = 1'b0;
    o_product = {w_sign, w_exp_r[4:0], w_frac_r};
    if (w_ca == NAN || w_cb == NAN || (w_ca == INF && w_cb == ZERO) || (w_ca == ZERO && w_cb == INF))
      o_product = FP16_QNAN;
    else if (w_ca == INF || w_cb == INF)
      o_product = FP16_INF | {w_sign, 15'd0};
    else if (w_ca == ZERO || w_cb == ZERO)
      o_product = {w_sign, 15'd0};
    else if (w_exp_r >= $signed(8'(FP16_EXP_MAX))) begin
      o_product = FP16_INF | {w_sign, 15'd0};
      o_overflow = 1'b1;
    end else if (w_exp_r <= 8'sd0)
      o_product = {w_sign, 15'd0};
  end
endmodule

// File: rtl/vmult_p.sv
// vmult_p: fp16 multiplier with one registered output stage, one operand pair per clock
// Ports: Clk2 clock; rst_n async active-low reset; A, B fp16 operands;
//        product registered fp16 result; Overflow registered finite-overflow flag.
// Build option: VMULT_RNE_EN (round-to-nearest-even; default truncates).
module vmult_p (
  input  logic        Clk2,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] product,
  output logic        Overflow
);
  import vmult_pkg::*;
  logic [15:0] w_product;
  logic w_overflow;
  vmult_p_core u_core (
    .i_a(A),
    .i_b(B),
    .o_product(w_product),
    .o_overflow(w_overflow)
  );
  always_ff @(posedge Clk2 or negedge rst_n)
    if (!rst_n) begin
      product <= 16'h0000;
      Overflow <= 1'b0;
    end else begin
      product <= w_product;
      Overflow <= w_overflow;
    end
endmodule

// File: tb/tb_vmult_p.sv
// tb_vmult_p: scoreboard-driven self-checking bench for vmult_p
module tb_vmult_p;
  logic Clk2 = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [15:0] product;
  logic Overflow;
  typedef struct packed {logic [15:0] p; logic o;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  vmult_p dut (
    .Clk2(Clk2),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .product(product),
    .Overflow(Overflow)
  );

  always #5 Clk2 = ~Clk2;

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ep, input logic eo);
    @(negedge Clk2);
    A = a;
    B = b;
    sb.push_back(exp_t'{p: ep, o: eo});
  endtask

  task automatic collect(input string name);
    exp_t e;
    @(posedge Clk2);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, product=%h Overflow=%b", name, product, Overflow);
    end else begin
      e = sb.pop_front();
      if (product !== e.p || Overflow !== e.o) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", name, product, Overflow, e.p, e.o);
      end
    end
  endtask

  task automatic step(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ep, input logic eo);
    drive(a, b, ep, eo);
    collect(name);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (product !== 16'h0000 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got %h/%b expected 0000/0", product, Overflow);
    end
    A = 16'h3C00;
    B = 16'h3C00;
    repeat (2) @(posedge Clk2);
    #1;
    checks++;
    if (product !== 16'h0000 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b expected 0000/0", product, Overflow);
    end
    @(negedge Clk2);
    rst_n = 1'b1;
  endtask

  task automatic test_latency;
    step("one_x_one", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
    drive(16'h3C00, 16'hBC00, 16'hBC00, 1'b0);
    #1;
    checks++;
    if (product !== 16'h3C00) begin
      errors++;
      $display("FAIL latency_hold: got %h expected 3C00 before edge", product);
    end
    collect("one_x_neg_one");
  endtask

  task automatic test_back_to_back;
    drive(16'h4000, 16'h4200, 16'h4600, 1'b0);
    collect("b2b_2x3");
    drive(16'hC000, 16'hC000, 16'h4400, 1'b0);
    collect("b2b_neg2xneg2");
    drive(16'h3FFF, 16'h3FFF, 16'h43FE, 1'b0);
    collect("b2b_max_mant");
    drive(16'h5800, 16'h5800, 16'h7400, 1'b0);
    collect("b2b_128x128");
  endtask

  task automatic test_overflow;
    step("ovf_pos", 16'h7BFF, 16'h4000, 16'h7C00, 1'b1);
    step("ovf_clear", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
    step("ovf_neg", 16'h7BFF, 16'hC000, 16'hFC00, 1'b1);
    step("ovf_256sq", 16'h5C00, 16'h5C00, 16'h7C00, 1'b1);
    step("max_finite", 16'h7BFF, 16'h3C00, 16'h7BFF, 1'b0);
  endtask

  task automatic test_special;
    step("zero_x_inf", 16'h0000, 16'h7C00, 16'h7E00, 1'b0);
    step("nan_x_one", 16'h7E01, 16'h3C00, 16'h7E00, 1'b0);
    step("negnan_pos", 16'hFE00, 16'h3C00, 16'h7E00, 1'b0);
    step("inf_x_one", 16'h7C00, 16'h3C00, 16'h7C00, 1'b0);
    step("neginf_x_one", 16'hFC00, 16'h3C00, 16'hFC00, 1'b0);
    step("inf_x_negzero", 16'h7C00, 16'h8000, 16'h7E00, 1'b0);
    step("negzero_x_one", 16'h8000, 16'h3C00, 16'h8000, 1'b0);
    step("zero_x_neg_one", 16'h0000, 16'hBC00, 16'h8000, 1'b0);
    step("subnormal_flush", 16'h0001, 16'h3C00, 16'h0000, 1'b0);
  endtask

  task automatic test_underflow;
    step("min_normal_sq", 16'h0400, 16'h0400, 16'h0000, 1'b0);
    step("exp_one", 16'h2000, 16'h2000, 16'h0400, 1'b0);
    step("exp_zero", 16'h1C00, 16'h2000, 16'h0000, 1'b0);
  endtask

  task automatic test_rounding;
`ifdef VMULT_RNE_EN
    step("tie_even", 16'h3E00, 16'h3C01, 16'h3E02, 1'b0);
`else
    step("truncate", 16'h3E00, 16'h3C01, 16'h3E01, 1'b0);
`endif
  endtask

  task automatic test_midstream_reset;
    step("pre_reset", 16'h7BFF, 16'h4000, 16'h7C00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (product !== 16'h0000 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b expected 0000/0", product, Overflow);
    end
    @(negedge Clk2);
    rst_n = 1'b1;
    step("post_reset", 16'h4000, 16'h4200, 16'h4600, 1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_special();
    test_underflow();
    test_rounding();
    test_midstream_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
